uart_rx_param: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_param_if.sv | 28 ++
 rtl/uart_rx_sync.sv | 44 ++++
 rtl/uart_rx_param.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the parametrised UART receiver.
//   uart_rx_state_t  receiver FSM state encoding
//   UART_IDLE_LEVEL  level of an idle (marking) RX line
//   PARITY_EVEN/ODD  parity sense constants
//   parity_calc()    expected parity bit for a data word (zero-extended to 9 bits)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_rx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam logic PARITY_EVEN     = 1'b0;
  localparam logic PARITY_ODD      = 1'b1;

  // Expected parity bit: XOR of all data bits, inverted for odd parity.
  function automatic logic parity_calc(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: RX line plus received-byte outputs of the UART receiver.
//   bit_in      serial RX line (asynchronous, idle high)
//   data_out    last received data word
//   received    one-cycle pulse, good frame
//   busy        frame in progress (start edge until end/abort)
//   frame_err   one-cycle pulse, stop bit sampled low
//   parity_err  one-cycle pulse, parity mismatch
// master: the receiver; slave: the line driver / byte consumer.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 bit_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 received;
  logic                 busy;
  logic                 frame_err;
  logic                 parity_err;

  modport master (
    input  bit_in,
    output data_out, received, busy, frame_err, parity_err
  );

  modport slave (
    output bit_in,
    input  data_out, received, busy, frame_err, parity_err
  );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous RX line plus a
// falling-edge detector on the synchronised level.
//   clk, rst_n  clock and asynchronous active-low reset (flops reset to idle)
//   bit_in      raw RX pin
//   rx_s        synchronised RX level
//   fall        high for one cycle when rx_s goes 1 -> 0
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic bit_in,
  output logic rx_s,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next-state of the synchroniser chain and the edge-detect history flop.
  always_comb begin
    meta_d = bit_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchroniser registers; reset to the idle line level so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= UART_IDLE_LEVEL;
      sync_q <= UART_IDLE_LEVEL;
      prev_q <= UART_IDLE_LEVEL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rx_s = sync_q;
  assign fall = (sync_q != UART_IDLE_LEVEL) && (prev_q == UART_IDLE_LEVEL);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver (LSB first).
//   clk    clock at OVERSAMPLE x baud
//   rst_n  asynchronous active-low reset; aborts any frame without pulses
//   rx_if  uart_rx_param_if.master: bit_in in; data_out, received, busy,
//          frame_err, parity_err out (all outputs registered)
// Optional feature macro UART_RX_PARITY_EN: when defined, one parity bit
// (sense PARITY_ODD) follows the data bits and parity_err is driven; when
// undefined there is no parity bit and parity_err stays 0.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_rx_param_if.master  rx_if
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
    $error("uart_rx_param: illegal parameter set");
  end

  logic rx_s;
  logic fall_s;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .bit_in (rx_if.bit_in),
    .rx_s   (rx_s),
    .fall   (fall_s)
  );

  uart_rx_state_t       state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 received_q, received_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 busy_q, busy_d;
  logic                 stop_ferr_s;
  logic                 perr_s;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0) ? uart_pkg::PARITY_ODD : PARITY_EVEN;
  logic perr_q, perr_d;
  assign perr_s = perr_q;
`else
  assign perr_s = 1'b0;
`endif

  // Framing error seen so far including the stop bit being sampled right now.
  assign stop_ferr_s = ferr_q | (rx_s != UART_IDLE_LEVEL);

  // Next-state and registered-output logic of the receive FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    stop_idx_d   = stop_idx_q;
    shift_d      = shift_q;
    ferr_d       = ferr_q;
    data_out_d   = data_out_q;
    received_d   = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d       = perr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fall_s) begin
          state_d = ST_START;
          cnt_d   = '0;
          ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
          perr_d  = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          // Line back high at mid start bit: treat as a glitch.
          if (rx_s == UART_IDLE_LEVEL) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_FULL) begin
          shift_d[bit_idx_q] = rx_s;
          cnt_d              = '0;
          if (bit_idx_q == BIT_LAST) begin
            stop_idx_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            state_d    = ST_PARITY;
`else
            state_d    = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == CNT_FULL) begin
          perr_d  = rx_s ^ parity_calc(9'(shift_q), PAR_SENSE);
          cnt_d   = '0;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (stop_idx_q == STOP_LAST) begin
            data_out_d   = shift_q;
            frame_err_d  = stop_ferr_s;
            parity_err_d = perr_s;
            received_d   = !stop_ferr_s && !perr_s;
            // A low final stop bit may be a break; wait for the line to rise.
            if (rx_s == UART_IDLE_LEVEL) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_BREAK;
            end
          end else begin
            ferr_d     = stop_ferr_s;
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BREAK: begin
        if (rx_s == UART_IDLE_LEVEL) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // FSM state, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      shift_q      <= '0;
      ferr_q       <= 1'b0;
      data_out_q   <= '0;
      received_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      shift_q      <= shift_d;
      ferr_q       <= ferr_d;
      data_out_q   <= data_out_d;
      received_q   <= received_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
      perr_q       <= perr_d;
`endif
    end
  end

  assign rx_if.data_out   = data_out_q;
  assign rx_if.received   = received_q;
  assign rx_if.busy       = busy_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed self-checking bench for uart_rx_param.
// Default build: 8N1, 16x. With UART_RX_PARITY_EN: 7 data bits, even parity.
module tb_uart_rx_param;

  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int DB = 7;
`else
  localparam int DB = 8;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(DB)) bus ();

  uart_rx_param #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB),
    .STOP_BITS  (1),
    .PARITY_ODD (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (bus)
  );

  int passed = 0;
  int total  = 0;

  int cyc = 0;
  int rcv_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
  int rcv_cyc_last = 0, rcv_cyc_prev = 0;
  logic [DB-1:0] rcv_data_last = '0, rcv_data_prev = '0;
  int frame_start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts output pulses and records when/what was received.
  always @(negedge clk) begin
    if (bus.received === 1'b1) begin
      rcv_cnt       <= rcv_cnt + 1;
      rcv_cyc_prev  <= rcv_cyc_last;
      rcv_cyc_last  <= cyc;
      rcv_data_prev <= rcv_data_last;
      rcv_data_last <= bus.data_out;
    end
    if (bus.frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (bus.parity_err === 1'b1) perr_cnt <= perr_cnt + 1;
  end

  task automatic send_bit(input logic b);
    bus.bit_in = b;
    repeat (OS) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.bit_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic has_par,
                            input logic par, input logic stop);
    frame_start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    if (has_par) send_bit(par);
    send_bit(stop);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.bit_in = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    total++; if (bus.received !== 1'b0) $display("FAIL reset_received: got %b want 0", bus.received); else passed++;
    total++; if (bus.frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); else passed++;
    total++; if (bus.parity_err !== 1'b0) $display("FAIL reset_parity_err: got %b want 0", bus.parity_err); else passed++;
    total++; if (bus.data_out !== '0) $display("FAIL reset_data: got %h want 0", bus.data_out); else passed++;
    rst_n = 1'b1;
    idle(4);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int rb, pb, fb;
    // 7'h55 has four ones: correct even parity bit is 0; send 1.
    rb = rcv_cnt; pb = perr_cnt; fb = ferr_cnt;
    send_frame(7'h55, 1'b1, 1'b1, 1'b1);
    idle(8);
    total++; if (perr_cnt - pb !== 1) $display("FAIL par_bad_perr: got %0d want 1", perr_cnt - pb); else passed++;
    total++; if (rcv_cnt - rb !== 0) $display("FAIL par_bad_rcv: got %0d want 0", rcv_cnt - rb); else passed++;
    total++; if (bus.data_out !== 7'h55) $display("FAIL par_bad_data: got %h want 55", bus.data_out); else passed++;
    rb = rcv_cnt; pb = perr_cnt;
    send_frame(7'h55, 1'b1, 1'b0, 1'b1);
    idle(8);
    total++; if (rcv_cnt - rb !== 1) $display("FAIL par_good_rcv: got %0d want 1", rcv_cnt - rb); else passed++;
    total++; if (perr_cnt - pb !== 0) $display("FAIL par_good_perr: got %0d want 0", perr_cnt - pb); else passed++;
    total++; if (rcv_data_last !== 7'h55) $display("FAIL par_good_data: got %h want 55", rcv_data_last); else passed++;
    // 7'h13 has three ones: even parity bit is 1.
    rb = rcv_cnt;
    send_frame(7'h13, 1'b1, 1'b1, 1'b1);
    idle(8);
    total++; if (rcv_cnt - rb !== 1) $display("FAIL par_odd_ones_rcv: got %0d want 1", rcv_cnt - rb); else passed++;
    total++; if (rcv_data_last !== 7'h13) $display("FAIL par_odd_ones_data: got %h want 13", rcv_data_last); else passed++;
    total++; if (ferr_cnt - fb !== 0) $display("FAIL par_ferr: got %0d want 0", ferr_cnt - fb); else passed++;
  endtask
`else
  task automatic test_basic();
    int rb, fb;
    rb = rcv_cnt; fb = ferr_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    idle(8);
    total++; if (rcv_cnt - rb !== 1) $display("FAIL basic_count: got %0d want 1", rcv_cnt - rb); else passed++;
    // 2 sync + 1 edge + 8 (half start) + 8*16 data + 16 stop = 155 clocks.
    total++; if (rcv_cyc_last - frame_start_cyc !== 155) $display("FAIL basic_latency: got %0d want 155", rcv_cyc_last - frame_start_cyc); else passed++;
    total++; if (bus.data_out !== 8'hA5) $display("FAIL basic_data: got %h want a5", bus.data_out); else passed++;
    total++; if (ferr_cnt - fb !== 0) $display("FAIL basic_ferr: got %0d want 0", ferr_cnt - fb); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL basic_busy: got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_glitch();
    int rb, fb, busy_cycles;
    rb = rcv_cnt; fb = ferr_cnt; busy_cycles = 0;
    bus.bit_in = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 4) bus.bit_in = 1'b1;
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cycles++;
    end
    total++; if ((busy_cycles >= 1 && busy_cycles <= 8) !== 1'b1) $display("FAIL glitch_busy_len: got %0d want 1..8", busy_cycles); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL glitch_busy_end: got %b want 0", bus.busy); else passed++;
    total++; if (rcv_cnt - rb !== 0) $display("FAIL glitch_rcv: got %0d want 0", rcv_cnt - rb); else passed++;
    total++; if (ferr_cnt - fb !== 0) $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt - fb); else passed++;
    total++; if (bus.data_out !== 8'hA5) $display("FAIL glitch_data: got %h want a5", bus.data_out); else passed++;
  endtask

  task automatic test_frame_err();
    int rb, fb;
    rb = rcv_cnt; fb = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    bus.bit_in = 1'b0;
    repeat (40) @(negedge clk);
    total++; if (ferr_cnt - fb !== 1) $display("FAIL ferr_count: got %0d want 1", ferr_cnt - fb); else passed++;
    total++; if (rcv_cnt - rb !== 0) $display("FAIL ferr_rcv: got %0d want 0", rcv_cnt - rb); else passed++;
    total++; if (bus.data_out !== 8'h3C) $display("FAIL ferr_data: got %h want 3c", bus.data_out); else passed++;
    total++; if (bus.busy !== 1'b1) $display("FAIL ferr_busy_break: got %b want 1", bus.busy); else passed++;
    idle(8);
    total++; if (bus.busy !== 1'b0) $display("FAIL ferr_busy_release: got %b want 0", bus.busy); else passed++;
    total++; if (rcv_cnt - rb !== 0) $display("FAIL ferr_no_retrigger: got %0d want 0", rcv_cnt - rb); else passed++;
  endtask

  task automatic test_back_to_back();
    int rb;
    rb = rcv_cnt;
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    idle(8);
    total++; if (rcv_cnt - rb !== 2) $display("FAIL b2b_count: got %0d want 2", rcv_cnt - rb); else passed++;
    total++; if (rcv_cyc_last - rcv_cyc_prev !== 160) $display("FAIL b2b_spacing: got %0d want 160", rcv_cyc_last - rcv_cyc_prev); else passed++;
    total++; if (rcv_data_prev !== 8'h00) $display("FAIL b2b_first: got %h want 00", rcv_data_prev); else passed++;
    total++; if (rcv_data_last !== 8'hFF) $display("FAIL b2b_second: got %h want ff", rcv_data_last); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int rb, fb;
    rb = rcv_cnt; fb = ferr_cnt;
    // 0x5A LSB first: 0,1,0,1,...; abort half-way through bit 3.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    bus.bit_in = 1'b1;
    repeat (8) @(negedge clk);
    total++; if (bus.busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", bus.busy); else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.busy); else passed++;
    total++; if (bus.data_out !== 8'h00) $display("FAIL rstmid_data: got %h want 00", bus.data_out); else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(OS * 12);
    total++; if (rcv_cnt - rb !== 0) $display("FAIL rstmid_no_rcv: got %0d want 0", rcv_cnt - rb); else passed++;
    total++; if (ferr_cnt - fb !== 0) $display("FAIL rstmid_no_ferr: got %0d want 0", ferr_cnt - fb); else passed++;
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    idle(8);
    total++; if (rcv_cnt - rb !== 1) $display("FAIL rstmid_rcv_after: got %0d want 1", rcv_cnt - rb); else passed++;
    total++; if (bus.data_out !== 8'h81) $display("FAIL rstmid_data_after: got %h want 81", bus.data_out); else passed++;
  endtask
`endif

  initial begin
    bus.bit_in = 1'b1;
    test_reset();
`ifdef UART_RX_PARITY_EN
    test_parity();
`else
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1, "timeout");
  end

endmodule
